// File: rtl/mem_read_arbiter.sv
// Two-port read arbiter in front of the single-port program/data RAM.
// Port 0 has fixed priority; a saturating wait counter forces port 1 through.
module mem_read_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rstrb,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] MAXW = 8'(MAX_WAIT);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_owner;
    logic [7:0]        r_wait_cnt;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;
    logic              r_m0_rvalid;
    logic              r_m1_rvalid;
    logic              w_any;
    logic              w_grant1;
    logic              w_take;

    always_comb begin
        w_any    = m0_req | m1_req;
        w_grant1 = m1_req & (~m0_req | (r_wait_cnt == MAXW));
        w_take   = 1'b0;
        w_next   = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_take = 1'b1;
                    w_next = READ;
                end
            end
            READ:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_owner     <= 1'b0;
            r_wait_cnt  <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            if (w_take) begin
                r_addr  <= w_grant1 ? m1_addr : m0_addr;
                r_owner <= w_grant1;
                if (w_grant1)
                    r_wait_cnt <= '0;
                else if (m1_req && (r_wait_cnt < MAXW))
                    r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            // Memory registers its output, so data is valid in RESP.
            if (r_state == RESP) begin
                if (r_owner) begin
                    r_m1_rdata  <= mem_rdata;
                    r_m1_rvalid <= 1'b1;
                end else begin
                    r_m0_rdata  <= mem_rdata;
                    r_m0_rvalid <= 1'b1;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_rstrb = (r_state == READ);
    assign busy      = (r_state != IDLE);
    assign owner     = r_owner;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;

endmodule
